mem_scan_ctrl: RTL and testbench

Read-side sequencer for the 32×3 board memory. It steps a read address through all 32 locations at a fixed tick rate and waits out the memory's read latency. It then latches the returned word together with its address into stable display registers for the HEX drivers. It sits directly downstream of the memory's read port and upstream of the seg7 conversion logic. Writes from the switches are not affected.

---
 rtl/mem_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_scan_ctrl.sv
// ============================================================================
// Module   : mem_scan_ctrl
// Brief    : Read-side sequencer for the board memory. Steps rd_addr through
//            every location once per tick, waits out the read latency, then
//            latches the returned word and its address into display registers.
//            Optional feature macro: SCAN_PAUSE_EN (honours the pause input).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_scan_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              pause,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_lat_w  = $clog2(RD_LAT + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(RD_LAT);

    // READ waits for the memory to return data, HOLD shows the captured word
    typedef enum logic [0:0] {
        ST_READ = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_q,      state_d;
    logic [c_lat_w-1:0]  lat_cnt_q,    lat_cnt_d;
    logic [c_tick_w-1:0] tick_cnt_q,   tick_cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q,    rd_addr_d;
    logic [ADDR_W-1:0]   disp_addr_q,  disp_addr_d;
    logic [DATA_W-1:0]   disp_data_q,  disp_data_d;
    logic                disp_valid_q, disp_valid_d;
    logic                wrap_q,       wrap_d;

    logic w_pause_act;
    logic w_tick;

`ifdef SCAN_PAUSE_EN
    assign w_pause_act = pause;
`else
    // Port kept for board-level compatibility; the scan is free-running
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_pause_act    = 1'b0;
`endif

    // A pause holds the tick counter at zero, which also suppresses ticks
    assign w_tick = (tick_cnt_q == c_tick_last) && !w_pause_act;

    // Next-state logic for the tick divider, scan FSM and display registers
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rd_addr_d    = rd_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        wrap_d       = 1'b0;

        if (w_pause_act || (tick_cnt_q == c_tick_last)) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + c_tick_w'(1);
        end

        case (state_q)
            ST_READ: begin
                // Counting 0..RD_LAT gives the memory RD_LAT full cycles after
                // the first edge that sees the new address before capture
                if (lat_cnt_q == c_lat_last) begin
                    disp_addr_d  = rd_addr_q;
                    disp_data_d  = rd_data;
                    disp_valid_d = 1'b1;
                    lat_cnt_d    = '0;
                    state_d      = ST_HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + c_lat_w'(1);
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    wrap_d    = &rd_addr_q;
                    state_d   = ST_READ;
                end
            end
            default: state_d = ST_READ;
        endcase
    end

    // State and output registers; reset restarts the scan at address 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_READ;
            lat_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            rd_addr_q    <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            rd_addr_q    <= rd_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_scan_ctrl.sv
// ============================================================================
// Module   : tb_mem_scan_ctrl
// Brief    : Directed bench for mem_scan_ctrl with TICK_DIV = 8. One instance
//            uses RD_LAT = 1 behind a registered RAM, the other RD_LAT = 3
//            behind a three-stage read pipe. Memory word k = k mod 8.
//            Pause behaviour is checked when SCAN_PAUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       pause;
    logic [4:0] rd_addr1, disp_addr1, rd_addr3, disp_addr3;
    logic [2:0] rd_data1, disp_data1, rd_data3, disp_data3;
    logic       disp_valid1, wrap1, disp_valid3, wrap3;

    logic [2:0] mem1 [32];
    logic [2:0] mem3 [32];
    logic [2:0] p0, p1;

    int n_tests = 0;
    int n_fail  = 0;

    mem_scan_ctrl #(.ADDR_W(5), .DATA_W(3), .TICK_DIV(8), .RD_LAT(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr1),
        .rd_data   (rd_data1),
        .pause     (pause),
        .disp_addr (disp_addr1),
        .disp_data (disp_data1),
        .disp_valid(disp_valid1),
        .wrap      (wrap1)
    );

    mem_scan_ctrl #(.ADDR_W(5), .DATA_W(3), .TICK_DIV(8), .RD_LAT(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr3),
        .rd_data   (rd_data3),
        .pause     (pause),
        .disp_addr (disp_addr3),
        .disp_data (disp_data3),
        .disp_valid(disp_valid3),
        .wrap      (wrap3)
    );

    // Registered-output RAM, one cycle of read latency
    always @(posedge clk) rd_data1 <= mem1[rd_addr1];

    // Three-cycle read pipe for the RD_LAT = 3 instance
    always @(posedge clk) begin
        p0       <= mem3[rd_addr3];
        p1       <= p0;
        rd_data3 <= p1;
    end

    task automatic check(input string tag, input int n, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    initial begin
        int ea, eda, edd, v_cnt, w_cnt;
        int ea3, eda3;

        for (int k = 0; k < 32; k++) begin
            mem1[k] = 3'(k % 8);
            mem3[k] = 3'(k % 8);
        end
        rd_data1 = '0;
        rd_data3 = '0;
        p0       = '0;
        p1       = '0;
        reset    = 1'b0;
        pause    = 1'b0;
        v_cnt    = 0;
        w_cnt    = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ---- Phase 1: reset release, full sweep, latency, hidden write ----
        // Sample n is taken on the falling edge after rising edge En.
        for (int n = 0; n <= 395; n++) begin
            @(negedge clk);
            ea   = ((n + 1) / 8) % 32;
            eda  = (n < 1) ? 0 : ((n - 1) / 8) % 32;
            edd  = (eda == 3 && n >= 281) ? 7 : eda % 8;
            eda3 = (n < 3) ? 0 : ((n - 3) / 8) % 32;

            check("rd_addr1",    n, rd_addr1,    ea);
            check("disp_valid1", n, disp_valid1, (n % 8 == 1) ? 1 : 0);
            check("disp_addr1",  n, disp_addr1,  eda);
            check("disp_data1",  n, disp_data1,  edd);
            check("wrap1",       n, wrap1,       (n == 255) ? 1 : 0);

            check("rd_addr3",    n, rd_addr3,    ea);
            check("disp_valid3", n, disp_valid3, (n % 8 == 3) ? 1 : 0);
            check("disp_addr3",  n, disp_addr3,  eda3);
            check("disp_data3",  n, disp_data3,  eda3 % 8);
            check("wrap3",       n, wrap3,       (n == 255) ? 1 : 0);

            if (n >= 1 && n <= 256) v_cnt += int'(disp_valid1);
            w_cnt += int'(wrap1);

            // Location 3 is on display here; the new word must stay hidden
            if (n == 27) mem1[3] = 3'd7;
        end
        check("valid_per_sweep", 0, v_cnt, 32);
        check("wrap_per_run",    0, w_cnt, 1);
        check("at_addr17",       395, rd_addr1, 17);

        // ---- Asynchronous reset in HOLD at address 17 ----
        #2 reset = 1'b0;
        #1;
        check("rst_rd_addr1",    0, rd_addr1,    0);
        check("rst_disp_addr1",  0, disp_addr1,  0);
        check("rst_disp_data1",  0, disp_data1,  0);
        check("rst_disp_valid1", 0, disp_valid1, 0);
        check("rst_wrap1",       0, wrap1,       0);
        check("rst_rd_addr3",    0, rd_addr3,    0);
        check("rst_disp_addr3",  0, disp_addr3,  0);
        check("rst_disp_data3",  0, disp_data3,  0);
        check("rst_disp_valid3", 0, disp_valid3, 0);
        check("rst_wrap3",       0, wrap3,       0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ---- Phase 2: restart from 0, pause window, written word shown ----
        for (int n = 0; n <= 95; n++) begin
            @(negedge clk);
`ifdef SCAN_PAUSE_EN
            ea  = (n < 43) ? ((n + 1) / 8) % 32 : ((n < 90) ? 5 : 6);
            eda = (n < 1) ? 0 : ((n < 92) ? (((n - 1) / 8 > 5) ? 5 : (n - 1) / 8) : 6);
            check("p_disp_valid1", n, disp_valid1,
                  (((n % 8 == 1) && n < 43) || n == 92) ? 1 : 0);
`else
            ea  = ((n + 1) / 8) % 32;
            eda = (n < 1) ? 0 : ((n - 1) / 8) % 32;
            check("p_disp_valid1", n, disp_valid1, (n % 8 == 1) ? 1 : 0);
`endif
            edd = (eda == 3) ? 7 : eda % 8;
            check("p_rd_addr1",   n, rd_addr1,   ea);
            check("p_disp_addr1", n, disp_addr1, eda);
            check("p_disp_data1", n, disp_data1, edd);
            check("p_wrap1",      n, wrap1,      0);

            if (n == 42) pause = 1'b1;
            if (n == 82) pause = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
